// File: rtl/logic_op_sequencer.sv
// Sequences the ALU logical unit through its four primitives (AND, OR, NOTB, NOP)
// to build AND/OR/NOTB/NOTA/NAND/NOR/XOR/XNOR, returning the result over valid/ready.
module logic_op_sequencer #(
    parameter int NBITS = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [NBITS-1:0] req_a,
    input  logic [NBITS-1:0] req_b,
    output logic [NBITS-1:0] lu_a,
    output logic [NBITS-1:0] lu_b,
    output logic [2:0]       lu_ctrl,
    input  logic [NBITS-1:0] lu_y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [NBITS-1:0] rsp_y,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    typedef enum logic [2:0] {SRC_ZERO, SRC_A, SRC_B, SRC_T1, SRC_T2} src_t;
    typedef enum logic [1:0] {DST_T1, DST_T2, DST_Y} dst_t;

    localparam logic [2:0] CTRL_NOP  = 3'b000;
    localparam logic [2:0] CTRL_AND  = 3'b001;
    localparam logic [2:0] CTRL_OR   = 3'b010;
    localparam logic [2:0] CTRL_NOTB = 3'b100;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_NOTB = 3'b010;
    localparam logic [2:0] OP_NOTA = 3'b011;
    localparam logic [2:0] OP_NAND = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;

    state_t           state, state_next;
    logic [2:0]       op;
    logic [2:0]       step;
    logic [NBITS-1:0] a_reg, b_reg, t1, t2;

    logic [2:0]       step_ctrl;
    src_t             src_a, src_b;
    dst_t             dst;
    logic             last;

    function automatic logic [NBITS-1:0] pick(input src_t s, input logic [NBITS-1:0] a,
                                              input logic [NBITS-1:0] b, input logic [NBITS-1:0] x1,
                                              input logic [NBITS-1:0] x2);
        case (s)
            SRC_A:   pick = a;
            SRC_B:   pick = b;
            SRC_T1:  pick = x1;
            SRC_T2:  pick = x2;
            default: pick = '0;
        endcase
    endfunction

    // Step table: which primitive runs, on which operands, and where lu_y lands.
    always_comb begin
        step_ctrl = CTRL_NOP;
        src_a     = SRC_ZERO;
        src_b     = SRC_ZERO;
        dst       = DST_Y;
        last      = 1'b1;
        case (op)
            OP_AND: begin
                step_ctrl = CTRL_AND;
                src_a     = SRC_A;
                src_b     = SRC_B;
            end
            OP_OR: begin
                step_ctrl = CTRL_OR;
                src_a     = SRC_A;
                src_b     = SRC_B;
            end
            OP_NOTB: begin
                step_ctrl = CTRL_NOTB;
                src_b     = SRC_B;
            end
            OP_NOTA: begin
                step_ctrl = CTRL_NOTB;
                src_b     = SRC_A;
            end
            OP_NAND, OP_NOR: begin
                if (step == 3'd0) begin
                    step_ctrl = (op == OP_NAND) ? CTRL_AND : CTRL_OR;
                    src_a     = SRC_A;
                    src_b     = SRC_B;
                    dst       = DST_T1;
                    last      = 1'b0;
                end else begin
                    step_ctrl = CTRL_NOTB;
                    src_b     = SRC_T1;
                end
            end
            default: begin
                // XOR = (A|B) & ~(A&B); XNOR inverts that once more.
                case (step)
                    3'd0: begin
                        step_ctrl = CTRL_OR;
                        src_a     = SRC_A;
                        src_b     = SRC_B;
                        dst       = DST_T1;
                        last      = 1'b0;
                    end
                    3'd1: begin
                        step_ctrl = CTRL_AND;
                        src_a     = SRC_A;
                        src_b     = SRC_B;
                        dst       = DST_T2;
                        last      = 1'b0;
                    end
                    3'd2: begin
                        step_ctrl = CTRL_NOTB;
                        src_b     = SRC_T2;
                        dst       = DST_T2;
                        last      = 1'b0;
                    end
                    3'd3: begin
                        step_ctrl = CTRL_AND;
                        src_a     = SRC_T1;
                        src_b     = SRC_T2;
                        dst       = (op == OP_XOR) ? DST_Y : DST_T1;
                        last      = (op == OP_XOR);
                    end
                    default: begin
                        step_ctrl = CTRL_NOTB;
                        src_b     = SRC_T1;
                    end
                endcase
            end
        endcase
    end

    always_comb begin
        lu_ctrl = CTRL_NOP;
        lu_a    = '0;
        lu_b    = '0;
        if (state == EXEC) begin
            lu_ctrl = step_ctrl;
            lu_a    = pick(src_a, a_reg, b_reg, t1, t2);
            lu_b    = pick(src_b, a_reg, b_reg, t1, t2);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = EXEC;
            EXEC:    if (last) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op    <= '0;
            step  <= '0;
            a_reg <= '0;
            b_reg <= '0;
            t1    <= '0;
            t2    <= '0;
            rsp_y <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op    <= req_op;
                        a_reg <= req_a;
                        b_reg <= req_b;
                        step  <= '0;
                    end
                end
                EXEC: begin
                    case (dst)
                        DST_T1:  t1 <= lu_y;
                        DST_T2:  t2 <= lu_y;
                        DST_Y:   rsp_y <= lu_y;
                        default: ;
                    endcase
                    step <= last ? 3'd0 : step + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Directed bench for logic_op_sequencer: a vector table of single operations plus
// hand-written reset-abort, backpressure and back-to-back sequences.
module tb_logic_op_sequencer;

    localparam int NBITS = 32;
    localparam logic [2:0] C_NOP  = 3'b000;
    localparam logic [2:0] C_AND  = 3'b001;
    localparam logic [2:0] C_OR   = 3'b010;
    localparam logic [2:0] C_NOTB = 3'b100;

    typedef struct {
        logic [2:0]       op;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [31:0]      y;
        int               steps;
        logic [4:0][2:0]  seq;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [2:0]       req_op = '0;
    logic [NBITS-1:0] req_a = '0;
    logic [NBITS-1:0] req_b = '0;
    logic [NBITS-1:0] lu_a, lu_b, lu_y;
    logic [2:0]       lu_ctrl;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [NBITS-1:0] rsp_y;
    logic             busy;

    int total = 0;
    int bad = 0;
    vec_t vecs[12];

    logic_op_sequencer #(.NBITS(NBITS)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .lu_a(lu_a), .lu_b(lu_b), .lu_ctrl(lu_ctrl), .lu_y(lu_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the logical unit the sequencer drives.
    always_comb begin
        case (lu_ctrl)
            C_AND:   lu_y = lu_a & lu_b;
            C_OR:    lu_y = lu_a | lu_b;
            C_NOTB:  lu_y = ~lu_b;
            default: lu_y = '0;
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("ctrl_legal", {31'b0, lu_ctrl inside {C_NOP, C_AND, C_OR, C_NOTB}}, 32'd1);
            if (lu_ctrl == C_NOTB) checkOutput("notb_lu_a_zero", lu_a, 32'd0);
            if (!busy || rsp_valid) begin
                checkOutput("quiet_ctrl", {29'b0, lu_ctrl}, 32'd0);
                checkOutput("quiet_lu_a", lu_a, 32'd0);
                checkOutput("quiet_lu_b", lu_b, 32'd0);
            end
        end
    end

    task automatic waitReady();
        int c = 0;
        while (!req_ready && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        checkOutput("ready_before_req", {31'b0, req_ready}, 32'd1);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int c;
        logic [4:0][2:0] obs;
        waitReady();
        req_valid = 1'b1;
        req_op    = v.op;
        req_a     = v.a;
        req_b     = v.b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;
        obs = '0;
        c = 0;
        while (!rsp_valid && c < 10) begin
            if (c < 5) obs[c[2:0]] = lu_ctrl;
            @(posedge clk); #1;
            c++;
        end
        checkOutput($sformatf("v%0d_latency", idx), c, v.steps);
        checkOutput($sformatf("v%0d_ctrl_seq", idx), {17'b0, obs}, {17'b0, v.seq});
        checkOutput($sformatf("v%0d_rsp_y", idx), rsp_y, v.y);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checkOutput($sformatf("v%0d_valid_drop", idx), {31'b0, rsp_valid}, 32'd0);
        checkOutput($sformatf("v%0d_ready_after", idx), {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        vecs[0]  = '{3'b000, 32'hF0F01234, 32'h0FF0FF00, 32'h00F01200, 1, {C_NOP, C_NOP, C_NOP, C_NOP, C_AND}};
        vecs[1]  = '{3'b001, 32'hF0F01234, 32'h0FF0FF00, 32'hFFF0FF34, 1, {C_NOP, C_NOP, C_NOP, C_NOP, C_OR}};
        vecs[2]  = '{3'b010, 32'hF0F01234, 32'h0FF0FF00, 32'hF00F00FF, 1, {C_NOP, C_NOP, C_NOP, C_NOP, C_NOTB}};
        vecs[3]  = '{3'b011, 32'hF0F01234, 32'h0FF0FF00, 32'h0F0FEDCB, 1, {C_NOP, C_NOP, C_NOP, C_NOP, C_NOTB}};
        vecs[4]  = '{3'b100, 32'hF0F01234, 32'h0FF0FF00, 32'hFF0FEDFF, 2, {C_NOP, C_NOP, C_NOP, C_NOTB, C_AND}};
        vecs[5]  = '{3'b101, 32'hF0F01234, 32'h0FF0FF00, 32'h000F00CB, 2, {C_NOP, C_NOP, C_NOP, C_NOTB, C_OR}};
        vecs[6]  = '{3'b110, 32'hF0F01234, 32'h0FF0FF00, 32'hFF00ED34, 4, {C_NOP, C_AND, C_NOTB, C_AND, C_OR}};
        vecs[7]  = '{3'b111, 32'hF0F01234, 32'h0FF0FF00, 32'h00FF12CB, 5, {C_NOTB, C_AND, C_NOTB, C_AND, C_OR}};
        vecs[8]  = '{3'b110, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 4, {C_NOP, C_AND, C_NOTB, C_AND, C_OR}};
        vecs[9]  = '{3'b111, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 5, {C_NOTB, C_AND, C_NOTB, C_AND, C_OR}};
        vecs[10] = '{3'b100, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 2, {C_NOP, C_NOP, C_NOP, C_NOTB, C_AND}};
        vecs[11] = '{3'b011, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1, {C_NOP, C_NOP, C_NOP, C_NOP, C_NOTB}};

        // Reset state, including a request presented while reset is held.
        req_valid = 1'b1;
        req_op    = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("rst_lu_ctrl", {29'b0, lu_ctrl}, 32'd0);
        checkOutput("rst_rsp_y", rsp_y, 32'd0);
        req_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_rst_idle", {31'b0, busy}, 32'd0);

        for (int i = 0; i < 12; i++) applyStimulus(vecs[i], i);

        // Reset in the middle of an XOR aborts it with no response.
        waitReady();
        req_valid = 1'b1;
        req_op    = 3'b110;
        req_a     = 32'hF0F01234;
        req_b     = 32'h0FF0FF00;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("abort_step_ctrl", {29'b0, lu_ctrl}, {29'b0, C_AND});
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort_lu_ctrl", {29'b0, lu_ctrl}, 32'd0);
        checkOutput("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        checkOutput("abort_rsp_y", rsp_y, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        checkOutput("abort_req_ready", {31'b0, req_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checkOutput("abort_no_rsp", {31'b0, rsp_valid}, 32'd0);
        end

        // Backpressure: response held for 10 cycles while request inputs churn.
        begin
            int c = 0;
            waitReady();
            req_valid = 1'b1;
            req_op    = 3'b110;
            req_a     = 32'hF0F01234;
            req_b     = 32'h0FF0FF00;
            @(posedge clk); #1;
            req_valid = 1'b0;
            while (!rsp_valid && c < 10) begin
                @(posedge clk); #1;
                c++;
            end
            checkOutput("bp_latency", c, 32'd4);
            for (int i = 0; i < 10; i++) begin
                req_valid = i[0];
                req_op    = 3'($urandom);
                req_a     = $urandom;
                req_b     = $urandom;
                @(posedge clk); #1;
                checkOutput("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
                checkOutput("bp_rsp_y", rsp_y, 32'hFF00ED34);
                checkOutput("bp_lu_ctrl", {29'b0, lu_ctrl}, 32'd0);
                checkOutput("bp_req_ready", {31'b0, req_ready}, 32'd0);
            end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            checkOutput("bp_release_valid", {31'b0, rsp_valid}, 32'd0);
            checkOutput("bp_release_busy", {31'b0, busy}, 32'd0);
        end

        // Back-to-back: req_valid held high, AND then OR, consumer always ready.
        waitReady();
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_op    = 3'b000;
        req_a     = 32'hF0F01234;
        req_b     = 32'h0FF0FF00;
        @(posedge clk); #1;
        req_op = 3'b001;
        @(posedge clk); #1;
        checkOutput("b2b_first_valid", {31'b0, rsp_valid}, 32'd1);
        checkOutput("b2b_first_y", rsp_y, 32'h00F01200);
        @(posedge clk); #1;
        checkOutput("b2b_gap_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("b2b_gap_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        checkOutput("b2b_second_busy", {31'b0, busy}, 32'd1);
        checkOutput("b2b_second_exec_ctrl", {29'b0, lu_ctrl}, {29'b0, C_OR});
        @(posedge clk); #1;
        checkOutput("b2b_second_valid", {31'b0, rsp_valid}, 32'd1);
        checkOutput("b2b_second_y", rsp_y, 32'hFFF0FF34);
        req_valid = 1'b0;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checkOutput("b2b_end_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("b2b_end_valid", {31'b0, rsp_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/logic_op_sequencer.md
# logic_op_sequencer

Multi-cycle requester that drives the ALU logical unit from the control side. It accepts one logical-operation request, latches its operands and issues a short sequence of primitive control codes (AND, OR, NOTB, NOP) to the logical unit. It captures each partial result and returns the final value over a valid/ready handshake. Compound operations (NOTA, NAND, NOR, XOR, XNOR) are thereby built from the unit's four primitives without widening the unit itself.

## Interface
- NBITS, 32 (global from definitions.svh), operand/result width
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- req_valid  in  1  request present
- req_ready  out  1  block can accept; equals (state == IDLE)
- req_op  in  3  operation: 000 AND, 001 OR, 010 NOTB, 011 NOTA, 100 NAND, 101 NOR, 110 XOR, 111 XNOR
- req_a, req_b  in  NBITS  operands
- lu_a, lu_b  out  NBITS  operands to logical unit
- lu_ctrl  out  3  logical-unit code: 001 AND, 010 OR, 100 NOTB, 000 NOP; no other value ever driven
- lu_y  in  NBITS  logical-unit result (combinational from lu_a/lu_b/lu_ctrl)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_y  out  NBITS  final result, registered
- busy  out  1  state != IDLE

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch op, A=req_a, B=req_b, clear step counter, go EXEC.
- EXEC: one primitive per cycle; lu_y captured into T1/T2 (NBITS each) or rsp_y at cycle end. Step table (dest <- ctrl(lu_a, lu_b)); lu_a is 0 whenever the code is NOTB:
  - AND: rsp_y <- AND(A,B). 1 step
  - OR: rsp_y <- OR(A,B). 1 step
  - NOTB: rsp_y <- NOTB(0,B). 1 step
  - NOTA: rsp_y <- NOTB(0,A). 1 step
  - NAND: T1 <- AND(A,B); rsp_y <- NOTB(0,T1). 2 steps
  - NOR: T1 <- OR(A,B); rsp_y <- NOTB(0,T1). 2 steps
  - XOR: T1 <- OR(A,B); T2 <- AND(A,B); T2 <- NOTB(0,T2); rsp_y <- AND(T1,T2). 4 steps
  - XNOR: XOR's first three steps, then T1 <- AND(T1,T2), then rsp_y <- NOTB(0,T1). 5 steps
- After the last step, go to RESP.
- RESP: rsp_valid=1 and rsp_y stable. On rsp_ready, go IDLE. While rsp_ready=0, hold indefinitely.
- Outside EXEC: lu_ctrl=000 (NOP), lu_a=lu_b=0.
- Request inputs are ignored outside IDLE. Operands are sampled only at acceptance, so later changes to req_a/req_b have no effect.
- Result width is exactly NBITS; no carry or flags.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, step=0, A=B=T1=T2=0, rsp_y=0, rsp_valid=0, busy=0, lu_ctrl=000, lu_a=lu_b=0. req_ready reads 1, but no acceptance occurs while rst_n is low.
- Acceptance at edge E0. EXEC steps occupy cycles E0..E(N-1), where N = step count. rsp_valid rises at edge EN.
- Latency from acceptance to rsp_valid: 1 cycle for AND/OR/NOTB/NOTA, 2 for NAND/NOR, 4 for XOR, 5 for XNOR.
- If rsp_ready=1 when rsp_valid rises, the handshake completes at the next edge. req_ready is 1 in the following cycle; no request overlaps an outstanding response.
- Minimum request spacing: N+2 cycles.
- Reset asserted mid-EXEC or mid-RESP aborts the operation immediately. The result is discarded and no rsp_valid is produced afterwards.
- req_valid held high continuously: a new request is accepted on each return to IDLE.

## Test plan
- Reset: assert rst_n=0 mid-XOR step 2 -> lu_ctrl=000, rsp_valid=0, busy=0 asynchronously. After release, req_ready=1.
- Single-step ops, a=0xF0F01234, b=0x0FF0FF00:
  - AND -> rsp_y=0x00F01200, rsp_valid 1 cycle after acceptance, lu_ctrl=001 for exactly one cycle.
  - NOTA -> rsp_y=0x0F0FEDCB.
- Two-step ops, same operands:
  - NAND -> 0xFF0FEDFF, lu_ctrl sequence 001,100.
  - NOR -> 0x000F00CB, lu_ctrl sequence 010,100.
  - Both at 2-cycle latency.
- Compound ops, same operands:
  - XOR -> 0xFF00ED34, lu_ctrl sequence 010,001,100,001.
  - XNOR -> 0x00FF12CB, lu_ctrl sequence 010,001,100,001,100.
  - Latencies 4 and 5.
- Backpressure: hold rsp_ready=0 for 10 cycles after XOR completes -> rsp_valid and rsp_y stable, lu_ctrl=000, req_ready=0. Toggling req_a/req_valid has no effect.
- Back-to-back: req_valid held high with AND then OR queued, rsp_ready=1 -> two responses with correct values, gap of exactly one IDLE cycle between them. lu_ctrl never takes a value outside {000,001,010,100}.
